// File: rtl/calc_stack.sv
// Button-driven RPN calculator: push switches or pop two operands and push the ALU result.
// Optional press debouncer enabled by defining CALC_STACK_DEBOUNCE_EN.
module calc_stack #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       btnu,
  input  logic                       btnd,
  input  logic                       mode,
  input  logic                       btnl,
  input  logic                       btnc,
  input  logic                       btnr,
  input  logic [WIDTH-1:0]           sw,
  output logic [WIDTH-1:0]           led,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err,
  output logic                       ovf
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int SHW = $clog2(WIDTH);

  logic             qual;
  logic             prev_q;
  logic             press;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

`ifdef CALC_STACK_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES+1);
  logic          db_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  // The level flips on the edge that completes DB_CYCLES stable samples.
  always_comb begin
    qual     = db_q;
    db_cnt_d = '0;
    if (btnd != db_q) begin
      if (db_cnt_q == DW'(DB_CYCLES-1))
        qual = btnd;
      else
        db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= qual;
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  assign qual = btnd;
`endif

  assign press = qual & ~prev_q;

  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, res, sum, diff;
  logic [SHW-1:0]   sh;
  logic             res_ovf;

  assign op   = {btnl, btnc, btnr};
  assign sum  = a + b;
  assign diff = a - b;
  assign sh   = b[SHW-1:0];

  always_comb begin
    b = '0;
    a = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == int'(count_q) - 1) b = stk_q[i];
      if (i == int'(count_q) - 2) a = stk_q[i];
    end
  end

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin
        res     = sum;
        res_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b011: begin
        res     = diff;
        res_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b100: res[0] = $signed(a) < $signed(b);
      3'b101: res = a << sh;
      3'b110: res = $unsigned($signed(a) >>> sh);
      default: res = a ^ b;
    endcase
  end

  always_comb begin
    stk_d   = stk_q;
    count_d = count_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (press) begin
      if (mode) begin
        if (count_q == CW'(DEPTH)) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (i == int'(count_q)) stk_d[i] = sw;
          count_d = count_q + 1'b1;
        end
      end else begin
        if (int'(count_q) < 2) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(count_q) - 2) stk_d[i] = res;
            if (i == int'(count_q) - 1) stk_d[i] = '0;
          end
          count_d = count_q - 1'b1;
          ovf_d   = res_ovf;
        end
      end
    end
  end

  // prev_q resets high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      prev_q  <= 1'b1;
      count_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      prev_q  <= qual;
      count_q <= count_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign led   = b;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign err   = err_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/calc_stack.md
CALC_STACK -- requirements
Module: calc_stack

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (minimum 4).
REQ-002 Parameter DEPTH, default 8, operand stack entries (minimum 2).
REQ-003 Parameter DB_CYCLES, default 4, debounce length in clk cycles; used only under CALC_STACK_DEBOUNCE_EN.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 btnu  input  1  reset, asynchronous, active-high.
REQ-006 btnd  input  1  action button; one action per press.
REQ-007 mode  input  1  1 = push sw, 0 = execute operation.
REQ-008 btnl, btnc, btnr  input  1 each  op code {btnl,btnc,btnr}.
REQ-009 sw  input  WIDTH  push operand.
REQ-010 led  output  WIDTH  top-of-stack value, 0 when empty.
REQ-011 count  output  $clog2(DEPTH+1)  entries held.
REQ-012 empty, full  output  1 each  count==0 / count==DEPTH.
REQ-013 err  output  1  sticky error flag.
REQ-014 ovf  output  1  signed overflow of the last executed op.

Function
REQ-015 Press = first clk edge where the qualified btnd is 1 and the registered previous qualified btnd is 0; holding btnd performs exactly one action.
REQ-016 mode, op, sw sampled on the press edge; all outputs reflect the action immediately after that edge (0-cycle latency from press edge).
REQ-017 Push with count<DEPTH: sw written on top, count+1; with count==DEPTH: stack unchanged, err=1.
REQ-018 Execute with count>=2: B=top, A=next; both popped, result pushed, count-1.
REQ-019 Execute with count<2: stack unchanged, err=1, ovf unchanged.
REQ-020 Ops: 000 A&B, 001 A|B, 010 A+B, 011 A-B, 100 signed(A<B)?1:0, 101 A<<B[$clog2(WIDTH)-1:0] logical, 110 A>>>B[$clog2(WIDTH)-1:0] arithmetic, 111 A^B.
REQ-021 Results truncated to WIDTH; ADD/SUB set ovf on two's-complement signed overflow, all other ops clear ovf.
REQ-022 Shift amount uses only low $clog2(WIDTH) bits of B; upper bits ignored.
REQ-023 err remains 1 until reset; errored actions never alter stack or count.
REQ-024 No action outside press edges; btnd bouncing within one held press produces no extra action.

Reset
REQ-025 btnu asserted: count=0, led=0, err=0, ovf=0, all stack entries 0, debounce counter 0, previous-btnd register set to 1.
REQ-026 btnd held through reset deassertion produces no action until released and pressed again.
REQ-027 btnu asserted mid-press aborts nothing pending; state is reset immediately, asynchronously.

Configuration
REQ-028 Macro CALC_STACK_DEBOUNCE_EN defined: qualified btnd changes only after raw btnd holds a new level for DB_CYCLES consecutive clk edges; press edge is DB_CYCLES edges after raw rise.
REQ-029 Macro undefined: qualified btnd equals raw btnd; no counter instantiated; DB_CYCLES ignored.

Verification (WIDTH=16, DEPTH=4, macro undefined unless stated)
REQ-030 Reset; push 0x354a, push 0x1234, execute 011 -> led=0x2316, count=1, ovf=0, err=0.
REQ-031 Push 0xa540, push 0x0001, execute 110 -> led=0xd2a0; push 0x0004 on 0xa540, execute 101 -> led=0x5400.
REQ-032 Push 0x7fff, push 0x0001, execute 010 -> led=0x8000, ovf=1; then execute 111 with count=1 -> err=1, led=0x8000, count=1.
REQ-033 Push 0x0001..0x0005 -> count=4, full=1, err=1, led=0x0004; btnd held 10 cycles on one push -> single action.
REQ-034 btnd held high across btnu release -> count=0 until release and new press.
REQ-035 Macro defined, DB_CYCLES=4: 2-cycle btnd glitch -> no push; 4-cycle hold of push 0x46ff -> led=0x46ff, count=1.
